// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Stands in for a 4x4 Pmod keypad on the row/column bus. A key code is
//   accepted over a valid/ready handshake and played back as a physical press:
//   bounce-in, stable hold, bounce-out, then a contact-open gap. While the
//   contact is closed, the row of the pressed key is pulled low whenever the
//   scanner strobes that key's column low.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   cols         column strobes from the scanner, active low
//   rows         emulated row lines, active low, registered, idle 4'hF
//   key_code     hex key to press, latched on acceptance
//   hold_cycles  stable-closed duration in cycles (0 behaves as 1)
//   press_valid  press request
//   press_ready  high only while idle
//   press_done   one-cycle pulse on the final gap cycle
//   strobe_count scanner hits on the pressed key this press, saturating
module keypad_emulator #(
   parameter int BOUNCE_CYCLES = 2000,
   parameter int BOUNCE_PERIOD = 250,
   parameter int GAP_CYCLES    = 100000,
   parameter int HOLD_W        = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        cols,
   output logic [3:0]        rows,
   input  logic [3:0]        key_code,
   input  logic [HOLD_W-1:0] hold_cycles,
   input  logic              press_valid,
   output logic              press_ready,
   output logic              press_done,
   output logic [7:0]        strobe_count
);

   localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
   localparam int PW = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BW-1:0] B_LAST = BW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
   localparam logic [PW-1:0] P_LAST = PW'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
   localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

   state_t            state_q, state_d;
   logic [1:0]        key_row_q, key_row_d;
   logic [1:0]        key_col_q, key_col_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic [PW-1:0]     pcnt_q, pcnt_d;
   logic              phase_q, phase_d;
   logic [GW-1:0]     gcnt_q, gcnt_d;
   logic [3:0]        rows_q, rows_d;
   logic [3:0]        cols_prev_q;
   logic [7:0]        strobe_q, strobe_d;
   logic              contact;
   logic              col_now;
   logic [3:0]        key_rc;

   // Returns {row, col} of a hex key on the Pmod keypad layout.
   function automatic logic [3:0] key_pos(input logic [3:0] k);
      case (k)
         4'h1:    key_pos = {2'd0, 2'd0};
         4'h2:    key_pos = {2'd0, 2'd1};
         4'h3:    key_pos = {2'd0, 2'd2};
         4'hA:    key_pos = {2'd0, 2'd3};
         4'h4:    key_pos = {2'd1, 2'd0};
         4'h5:    key_pos = {2'd1, 2'd1};
         4'h6:    key_pos = {2'd1, 2'd2};
         4'hB:    key_pos = {2'd1, 2'd3};
         4'h7:    key_pos = {2'd2, 2'd0};
         4'h8:    key_pos = {2'd2, 2'd1};
         4'h9:    key_pos = {2'd2, 2'd2};
         4'hC:    key_pos = {2'd2, 2'd3};
         4'h0:    key_pos = {2'd3, 2'd0};
         4'hF:    key_pos = {2'd3, 2'd1};
         4'hE:    key_pos = {2'd3, 2'd2};
         default: key_pos = {2'd3, 2'd3};  // key D
      endcase
   endfunction

   assign key_rc = key_pos(key_code);
   assign col_now = cols[key_col_q];

   // Bounce-in starts closed (phase 0), bounce-out starts open (phase 0).
   assign contact = (state_q == HOLD) ||
                    ((state_q == BOUNCE_IN) && !phase_q) ||
                    ((state_q == BOUNCE_OUT) && phase_q);

   always_comb begin
      state_d     = state_q;
      key_row_d   = key_row_q;
      key_col_d   = key_col_q;
      hold_d      = hold_q;
      hold_cnt_d  = hold_cnt_q;
      bcnt_d      = bcnt_q;
      pcnt_d      = pcnt_q;
      phase_d     = phase_q;
      gcnt_d      = gcnt_q;
      strobe_d    = strobe_q;
      press_ready = (state_q == IDLE);
      press_done  = 1'b0;

      // Falling edge of the pressed key's column while the contact is closed.
      if (contact && cols_prev_q[key_col_q] && !col_now && (strobe_q != 8'hFF))
         strobe_d = strobe_q + 8'd1;

      unique case (state_q)
         IDLE: begin
            if (press_valid) begin
               key_row_d = key_rc[3:2];
               key_col_d = key_rc[1:0];
               hold_d    = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
               strobe_d  = 8'd0;
               state_d   = (BOUNCE_CYCLES > 0) ? BOUNCE_IN : HOLD;
            end
         end
         BOUNCE_IN: begin
            if (bcnt_q == B_LAST) state_d = HOLD;
         end
         HOLD: begin
            if (hold_cnt_q == hold_q - 1'b1)
               state_d = (BOUNCE_CYCLES > 0) ? BOUNCE_OUT : GAP;
         end
         BOUNCE_OUT: begin
            if (bcnt_q == B_LAST) state_d = GAP;
         end
         GAP: begin
            if (gcnt_q == G_LAST) begin
               press_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Every state change restarts all timers so each phase counts from 0.
      if (state_d != state_q) begin
         hold_cnt_d = '0;
         bcnt_d     = '0;
         pcnt_d     = '0;
         phase_d    = 1'b0;
         gcnt_d     = '0;
      end else begin
         case (state_q)
            BOUNCE_IN, BOUNCE_OUT: begin
               bcnt_d = bcnt_q + 1'b1;
               if (pcnt_q == P_LAST) begin
                  pcnt_d  = '0;
                  phase_d = ~phase_q;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
            end
            HOLD:    hold_cnt_d = hold_cnt_q + 1'b1;
            GAP:     gcnt_d = gcnt_q + 1'b1;
            default: ;
         endcase
      end

      rows_d = (contact && !col_now) ? ~(4'b0001 << key_row_q) : 4'hF;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         key_row_q   <= 2'd0;
         key_col_q   <= 2'd0;
         hold_q      <= HOLD_W'(1);
         hold_cnt_q  <= '0;
         bcnt_q      <= '0;
         pcnt_q      <= '0;
         phase_q     <= 1'b0;
         gcnt_q      <= '0;
         rows_q      <= 4'hF;
         cols_prev_q <= 4'hF;
         strobe_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         key_row_q   <= key_row_d;
         key_col_q   <= key_col_d;
         hold_q      <= hold_d;
         hold_cnt_q  <= hold_cnt_d;
         bcnt_q      <= bcnt_d;
         pcnt_q      <= pcnt_d;
         phase_q     <= phase_d;
         gcnt_q      <= gcnt_d;
         rows_q      <= rows_d;
         cols_prev_q <= cols;
         strobe_q    <= strobe_d;
      end
   end

   assign rows         = rows_q;
   assign strobe_count = strobe_q;

endmodule
